// File: rtl/ats21_cmd_feeder.sv
// Two 32-bit command FIFOs (channel A and B), drained in lock-step as paired
// upper/lower half-word beats toward the downstream alarm/timer block.

module ats21_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] head,
    output logic        not_full,
    output logic        not_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign not_full  = (count < CW'(DEPTH));
    assign not_empty = (count != '0);
    assign head      = not_empty ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module ats21_cmd_feeder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmdA_valid,
    input  logic [31:0] cmdA,
    output logic        cmdA_ready,
    input  logic        cmdB_valid,
    input  logic [31:0] cmdB,
    output logic        cmdB_ready,
    input  logic        ready,
    output logic        req,
    output logic [15:0] ctrlA,
    output logic [15:0] ctrlB,
    output logic        busy,
    output logic [15:0] cmds_sent
);
    typedef enum logic [1:0] {
        IDLE,
        UPPER,
        LOWER
    } state_t;

    state_t      state;
    logic [31:0] holdA;
    logic [31:0] holdB;
    logic [31:0] headA;
    logic [31:0] headB;
    logic        a_not_empty;
    logic        b_not_empty;
    logic        start;
    logic        pushA;
    logic        pushB;
    logic        popA;
    logic        popB;

    assign pushA = cmdA_valid && cmdA_ready;
    assign pushB = cmdB_valid && cmdB_ready;
    assign start = (state == IDLE) && (a_not_empty || b_not_empty);
    assign popA  = start && a_not_empty;
    assign popB  = start && b_not_empty;

    ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (pushA),
        .din       (cmdA),
        .pop       (popA),
        .head      (headA),
        .not_full  (cmdA_ready),
        .not_empty (a_not_empty)
    );

    ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (pushB),
        .din       (cmdB),
        .pop       (popB),
        .head      (headB),
        .not_full  (cmdB_ready),
        .not_empty (b_not_empty)
    );

    // An empty channel reads back 32'h0 from its FIFO, so it rides along as a NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            holdA     <= 32'h0;
            holdB     <= 32'h0;
            req       <= 1'b0;
            busy      <= 1'b0;
            ctrlA     <= 16'h0;
            ctrlB     <= 16'h0;
            cmds_sent <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        holdA <= headA;
                        holdB <= headB;
                        ctrlA <= headA[31:16];
                        ctrlB <= headB[31:16];
                        req   <= 1'b1;
                        busy  <= 1'b1;
                        state <= UPPER;
                    end
                end
                UPPER: begin
                    if (ready) begin
                        ctrlA <= holdA[15:0];
                        ctrlB <= holdB[15:0];
                        state <= LOWER;
                    end
                end
                LOWER: begin
                    if (ready) begin
                        ctrlA     <= 16'h0;
                        ctrlB     <= 16'h0;
                        req       <= 1'b0;
                        busy      <= 1'b0;
                        cmds_sent <= cmds_sent + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ctrlA <= 16'h0;
                    ctrlB <= 16'h0;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ats21_cmd_feeder.sv
// Self-checking bench for ats21_cmd_feeder: directed scenarios plus randomized
// traffic compared against a queue-based transfer model.

module tb_ats21_cmd_feeder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmdA_valid = 1'b0;
    logic        cmdB_valid = 1'b0;
    logic [31:0] cmdA = 32'h0;
    logic [31:0] cmdB = 32'h0;
    logic        ready = 1'b0;
    logic        cmdA_ready;
    logic        cmdB_ready;
    logic        req;
    logic        busy;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic [15:0] cmds_sent;

    int errors = 0;
    int checks = 0;

    logic [31:0] qA[$];
    logic [31:0] qB[$];
    logic [31:0] curA = 32'h0;
    logic [31:0] curB = 32'h0;
    int          beatsLeft = 0;
    logic [15:0] mSent = 16'h0;
    logic [15:0] sentOffset = 16'h0;
    logic        mPushA;
    logic        mPushB;

    ats21_cmd_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmdA_valid (cmdA_valid),
        .cmdA       (cmdA),
        .cmdA_ready (cmdA_ready),
        .cmdB_valid (cmdB_valid),
        .cmdB       (cmdB),
        .cmdB_ready (cmdB_ready),
        .ready      (ready),
        .req        (req),
        .ctrlA      (ctrlA),
        .ctrlB      (ctrlB),
        .busy       (busy),
        .cmds_sent  (cmds_sent)
    );

    always #5 clk = ~clk;

    // Reference: whole commands wait in queues; a pair in flight needs two
    // accepted beats, and a new pair may start only from an idle cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            qA.delete();
            qB.delete();
            curA = 32'h0;
            curB = 32'h0;
            beatsLeft = 0;
            mSent = 16'h0;
        end else begin
            mPushA = cmdA_valid && (qA.size() < DEPTH);
            mPushB = cmdB_valid && (qB.size() < DEPTH);
            if (beatsLeft == 0) begin
                if (qA.size() != 0 || qB.size() != 0) begin
                    curA = 32'h0;
                    curB = 32'h0;
                    if (qA.size() != 0) curA = qA.pop_front();
                    if (qB.size() != 0) curB = qB.pop_front();
                    beatsLeft = 2;
                end
            end else if (ready) begin
                beatsLeft--;
                if (beatsLeft == 0) mSent++;
            end
            if (mPushA) qA.push_back(cmdA);
            if (mPushB) qB.push_back(cmdB);
        end
    end

    function automatic logic [15:0] halfOf(input logic [31:0] w, input int left);
        if (left == 2) return w[31:16];
        if (left == 1) return w[15:0];
        return 16'h0;
    endfunction

    function automatic logic modelIdle();
        return (beatsLeft == 0) && (qA.size() == 0) && (qB.size() == 0);
    endfunction

    task automatic applyStimulus(input logic va, input logic [31:0] a,
                                 input logic vb, input logic [31:0] b, input logic rdy);
        cmdA_valid = va;
        cmdA = a;
        cmdB_valid = vb;
        cmdB = b;
        ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cmdA_valid = 1'b1;
        cmdB_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req, busy, cmdA_ready, cmdB_ready} !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0011", {req, busy, cmdA_ready, cmdB_ready});
        end
        checks++;
        if ({ctrlA, ctrlB, cmds_sent} !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {ctrlA, ctrlB, cmds_sent});
        end
        cmdA_valid = 1'b0;
        cmdB_valid = 1'b0;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({req, busy, cmdA_ready, cmdB_ready} !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL post_reset_flags: got %b expected 0011", {req, busy, cmdA_ready, cmdB_ready});
        end
    endtask

    task automatic test_single();
        applyStimulus(1'b1, 32'h2A40_1234, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({req, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_push_cycle: got req/busy=%b expected 00", {req, busy});
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({req, busy, ctrlA, ctrlB} !== {2'b11, 16'h2A40, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL single_beat1: got %b %h %h expected 11 2a40 0000", {req, busy}, ctrlA, ctrlB);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({req, ctrlA, ctrlB} !== {1'b1, 16'h1234, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL single_beat2: got %b %h %h expected 1 1234 0000", req, ctrlA, ctrlB);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({req, busy, ctrlA, cmds_sent} !== {2'b00, 16'h0, 16'h1}) begin
            errors++;
            $display("[TB] FAIL single_done: got %b %h sent=%h expected 00 0000 0001", {req, busy}, ctrlA, cmds_sent);
        end
    endtask

    task automatic test_fill();
        logic [31:0] c[5];
        for (int i = 0; i < 5; i++) c[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, (i < 5) ? c[i] : 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
            checks++;
            if (cmdA_ready !== (qA.size() < DEPTH)) begin
                errors++;
                $display("[TB] FAIL fill_ready[%0d]: got %b expected %b", i, cmdA_ready, qA.size() < DEPTH);
            end
            if (i >= 1) begin
                checks++;
                if ({req, ctrlA} !== {1'b1, c[0][31:16]}) begin
                    errors++;
                    $display("[TB] FAIL fill_upper_stable[%0d]: got %b %h expected 1 %h", i, req, ctrlA, c[0][31:16]);
                end
            end
        end
        checks++;
        if (cmdA_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_full: got cmdA_ready=%b expected 0", cmdA_ready);
        end
        for (int i = 0; i < 60 && !modelIdle(); i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({req, ctrlA, ctrlB} !== {beatsLeft != 0, halfOf(curA, beatsLeft), halfOf(curB, beatsLeft)}) begin
                errors++;
                $display("[TB] FAIL fill_drain[%0d]: got %b %h %h expected %b %h %h", i, req, ctrlA, ctrlB,
                         beatsLeft != 0, halfOf(curA, beatsLeft), halfOf(curB, beatsLeft));
            end
        end
        checks++;
        if (cmds_sent !== 16'd6) begin
            errors++;
            $display("[TB] FAIL fill_count: got %0d expected 6", cmds_sent);
        end
    endtask

    task automatic test_stall();
        logic [31:0] c;
        logic        pattern[6];
        int          beats;
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        c = $urandom;
        beats = 0;
        applyStimulus(1'b1, c, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (req && pattern[i]) beats++;
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, pattern[i]);
            checks++;
            if ({req, ctrlA} !== {beatsLeft != 0, halfOf(c, beatsLeft)}) begin
                errors++;
                $display("[TB] FAIL stall_step[%0d]: got %b %h expected %b %h", i, req, ctrlA,
                         beatsLeft != 0, halfOf(c, beatsLeft));
            end
        end
        checks++;
        if (beats != 2) begin
            errors++;
            $display("[TB] FAIL stall_beats: got %0d beats expected 2", beats);
        end
        checks++;
        if (cmds_sent !== 16'd7) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d expected 7", cmds_sent);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[3];
        logic [31:0] b[3];
        logic [15:0] seenA[$];
        logic [15:0] seenB[$];
        int          cycles;
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom;
            b[i] = $urandom;
        end
        cycles = 0;
        for (int i = 0; i < 40 && (i < 3 || !modelIdle()); i++) begin
            if (req) begin
                seenA.push_back(ctrlA);
                seenB.push_back(ctrlB);
            end
            applyStimulus(i < 3, (i < 3) ? a[i % 3] : 32'h0, i < 3, (i < 3) ? b[i % 3] : 32'h0, 1'b1);
            cycles++;
        end
        checks++;
        if (seenA.size() != 6) begin
            errors++;
            $display("[TB] FAIL b2b_beats: got %0d beats expected 6", seenA.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if ({seenA[k], seenB[k]} !== {halfOf(a[k / 2], 2 - k % 2), halfOf(b[k / 2], 2 - k % 2)}) begin
                    errors++;
                    $display("[TB] FAIL b2b_pair[%0d]: got %h %h expected %h %h", k, seenA[k], seenB[k],
                             halfOf(a[k / 2], 2 - k % 2), halfOf(b[k / 2], 2 - k % 2));
                end
            end
        end
        checks++;
        if (cycles != 10) begin
            errors++;
            $display("[TB] FAIL b2b_cycles: got %0d expected 10", cycles);
        end
        checks++;
        if (cmds_sent !== 16'd10) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 10", cmds_sent);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c[3];
        for (int i = 0; i < 3; i++) c[i] = $urandom;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, c[i], 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({req, ctrlA} !== {1'b1, c[0][15:0]}) begin
            errors++;
            $display("[TB] FAIL rmid_lower: got %b %h expected 1 %h", req, ctrlA, c[0][15:0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req, busy, cmdA_ready, cmdB_ready, ctrlA, ctrlB, cmds_sent} !== {4'b0011, 48'h0}) begin
            errors++;
            $display("[TB] FAIL rmid_async: got %b %h %h %h expected 0011 0 0 0",
                     {req, busy, cmdA_ready, cmdB_ready}, ctrlA, ctrlB, cmds_sent);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({req, busy, cmds_sent} !== 18'h0) begin
                errors++;
                $display("[TB] FAIL rmid_quiet[%0d]: got %b sent=%h expected 00 0000", i, {req, busy}, cmds_sent);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 2) == 0, $urandom,
                          $urandom_range(0, 3) != 0);
            checks++;
            if ({req, busy, ctrlA, ctrlB} !== {beatsLeft != 0, beatsLeft != 0,
                                             halfOf(curA, beatsLeft), halfOf(curB, beatsLeft)}) begin
                errors++;
                $display("[TB] FAIL rand_beat[%0d]: got %b %h %h expected %b %h %h", i, {req, busy}, ctrlA, ctrlB,
                         beatsLeft != 0, halfOf(curA, beatsLeft), halfOf(curB, beatsLeft));
            end
            checks++;
            if ({cmdA_ready, cmdB_ready, cmds_sent} !== {qA.size() < DEPTH, qB.size() < DEPTH, mSent + sentOffset}) begin
                errors++;
                $display("[TB] FAIL rand_state[%0d]: got %b sent=%h expected %b sent=%h", i,
                         {cmdA_ready, cmdB_ready}, cmds_sent, {qA.size() < DEPTH, qB.size() < DEPTH}, mSent + sentOffset);
            end
        end
        for (int i = 0; i < 60 && !modelIdle(); i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({req, cmds_sent} !== {1'b0, mSent + sentOffset}) begin
            errors++;
            $display("[TB] FAIL rand_drain: got %b sent=%h expected 0 sent=%h", req, cmds_sent, mSent + sentOffset);
        end
    endtask

    task automatic test_wrap();
        force dut.cmds_sent = 16'hFFFE;
        #1 release dut.cmds_sent;
        sentOffset = 16'hFFFE - mSent;
        @(negedge clk);
        applyStimulus(1'b1, $urandom, 1'b1, $urandom, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (cmds_sent !== 16'hFFFF || cmds_sent !== mSent + sentOffset) begin
            errors++;
            $display("[TB] FAIL wrap_ffff: got %h expected ffff (model %h)", cmds_sent, mSent + sentOffset);
        end
        applyStimulus(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (cmds_sent !== 16'h0000 || cmds_sent !== mSent + sentOffset) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got %h expected 0000 (model %h)", cmds_sent, mSent + sentOffset);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
